// File: rtl/risc_v_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : risc_v_pkg
//  Purpose : Shared constants for the RV32I load/store unit: data width,
//            funct3 access-size encodings and the controller state encoding.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package risc_v_pkg;

  localparam int DATA_W = 32;

  // RV32I funct3 encodings for loads/stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LD_RD  = 3'd1,
    S_RMW_RD = 3'd2,
    S_ST_WR  = 3'd3,
    S_RESP   = 3'd4
  } lsu_state_t;

endpackage
`default_nettype wire

// File: rtl/risc_v_lsu_align.sv
`default_nettype none
// ============================================================================
//  Module  : risc_v_lsu_align
//  Purpose : Combinational lane logic for the load/store unit.
//            - load_data  : byte/half/word picked from `word` by addr, then
//                           sign- or zero-extended according to funct3.
//            - store_word : `word` with the addressed lane(s) replaced by the
//                           low bits of `wdata` (whole `wdata` for SW).
//            - legal      : funct3 is a valid load encoding and the address is
//                           naturally aligned for the access size.
//  Ports   : funct3[2:0], addr[1:0], word[31:0], wdata[31:0] in;
//            load_data[31:0], store_word[31:0], legal out.
//  Rev     : 1.0  initial release
// ============================================================================
module risc_v_lsu_align
  import risc_v_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] word,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] store_word,
  output logic              legal
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = addr[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_W:    load_data = word;
      F3_BU:   load_data = {24'd0, byte_sel};
      F3_HU:   load_data = {16'd0, half_sel};
      default: load_data = '0;
    endcase
  end

  // Store lanes only depend on the size bits; the unsigned variants never
  // reach here as stores because they are rejected at acceptance.
  always_comb begin
    store_word = word;
    case (funct3[1:0])
      2'b00: begin
        case (addr)
          2'd0:    store_word[7:0]   = wdata[7:0];
          2'd1:    store_word[15:8]  = wdata[7:0];
          2'd2:    store_word[23:16] = wdata[7:0];
          default: store_word[31:24] = wdata[7:0];
        endcase
      end
      2'b01: begin
        if (addr[1]) store_word[31:16] = wdata[15:0];
        else         store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

  always_comb begin
    case (funct3)
      F3_B, F3_BU: legal = 1'b1;
      F3_H, F3_HU: legal = ~addr[0];
      F3_W:        legal = (addr == 2'b00);
      default:     legal = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/risc_v_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module  : risc_v_load_store_unit
//  Purpose : RV32I byte/half/word load/store unit in front of a word-addressed
//            memory (synchronous write, combinational read). Sub-word stores
//            are done as read-modify-write; illegal or misaligned requests
//            return an error without touching memory.
//  Ports   : clk, rst (async, active high)
//            req_valid/req_ready, req_we, req_funct3, req_addr, req_wdata
//            rsp_valid (1-cycle pulse), rsp_rdata, rsp_err
//            mem_addr, mem_din, mem_we (out), mem_dout (in)
//  Rev     : 1.0  initial release
// ============================================================================
module risc_v_load_store_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32   // only 32 is supported
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout
);

  import risc_v_pkg::lsu_state_t;
  import risc_v_pkg::S_IDLE;
  import risc_v_pkg::S_LD_RD;
  import risc_v_pkg::S_RMW_RD;
  import risc_v_pkg::S_ST_WR;
  import risc_v_pkg::S_RESP;
  import risc_v_pkg::F3_W;

  lsu_state_t        state;
  logic [2:0]        r_f3;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] merge;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic              accept;
  logic              legal_req;
  logic [2:0]        al_f3;
  logic [1:0]        al_addr;
  logic [DATA_W-1:0] al_word;
  logic [DATA_W-1:0] al_load;
  logic [DATA_W-1:0] al_store;
  logic              al_legal;

  assign req_ready = (state == S_IDLE) & ~rst;
  assign accept    = req_valid & req_ready;

  // One aligner serves both phases: in IDLE it judges the incoming request,
  // afterwards it works on the latched request. The word input is the live
  // memory read during a load and the captured word during a store merge.
  assign al_f3   = (state == S_IDLE) ? req_funct3 : r_f3;
  assign al_addr = (state == S_IDLE) ? req_addr[1:0] : r_addr[1:0];
  assign al_word = (state == S_LD_RD) ? mem_dout : merge;

  risc_v_lsu_align u_align (
    .funct3     (al_f3),
    .addr       (al_addr),
    .word       (al_word),
    .wdata      (r_wdata),
    .load_data  (al_load),
    .store_word (al_store),
    .legal      (al_legal)
  );

  // The aligner accepts every load encoding; stores additionally exclude
  // the unsigned variants (funct3[2] set).
  assign legal_req = al_legal & ~(req_we & req_funct3[2]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      r_f3    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      merge   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            r_f3    <= req_funct3;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            if (!legal_req) begin
              rdata_q <= '0;
              err_q   <= 1'b1;
              state   <= S_RESP;
            end else if (!req_we) begin
              state   <= S_LD_RD;
            end else if (req_funct3 == F3_W) begin
              state   <= S_ST_WR;
            end else begin
              state   <= S_RMW_RD;
            end
          end
        end
        S_LD_RD: begin
          rdata_q <= al_load;
          err_q   <= 1'b0;
          state   <= S_RESP;
        end
        S_RMW_RD: begin
          merge <= mem_dout;
          state <= S_ST_WR;
        end
        S_ST_WR: begin
          rdata_q <= '0;
          err_q   <= 1'b0;
          state   <= S_RESP;
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Memory-side and response strobes are pure decodes of the state register,
  // so reset forces them inactive without waiting for a clock.
  assign mem_we    = (state == S_ST_WR);
  assign rsp_valid = (state == S_RESP);
  assign mem_addr  = (state == S_LD_RD || state == S_RMW_RD || state == S_ST_WR)
                     ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
  // For SW the aligner passes r_wdata straight through as the store word.
  assign mem_din   = mem_we ? al_store : '0;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_risc_v_load_store_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module  : tb_risc_v_load_store_unit
//  Purpose : Self-checking bench for risc_v_load_store_unit with a behavioural
//            byte-level reference model and a word memory attached to the DUT.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_risc_v_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_we;
  logic [31:0] mem_dout;

  always #5 clk = ~clk;

  risc_v_load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_we     (mem_we),
    .mem_dout   (mem_dout)
  );

  // ---------------- data memory attached to the DUT ----------------
  logic [31:0] mem [0:63];
  logic        mem_init;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'h8899AABB;
    return 32'(32'h13579BDF * (i + 1)) ^ 32'hA5A50000;
  endfunction

  assign mem_dout = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (mem_we) begin
      mem[mem_addr[7:2]] <= mem_din;
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [0:63];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Byte-level view: size from funct3, legality by encoding and natural
  // alignment, loads shift/mask/extend, stores overwrite individual bytes.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output logic ok, output logic [31:0] rdata,
                                output logic [31:0] eword, output int lat, output int nwr);
    int size, off, idx;
    longint v, half;
    logic [31:0] w;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    ok   = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    off  = int'(a % 4);
    idx  = int'((a / 4) % 64);
    if (off % size != 0) ok = 1'b0;
    rdata = '0;
    eword = ref_mem[idx];
    nwr   = 0;
    if (!ok) begin
      lat = 1;
    end else if (!we) begin
      lat = 2;
      v = longint'(ref_mem[idx] >> (8 * off));
      if (size < 4) begin
        half = longint'(1) << (8 * size - 1);
        v = v % (2 * half);
        if (!f3[2] && v >= half) v = v - 2 * half;
      end
      rdata = v[31:0];
    end else begin
      lat = (size == 4) ? 2 : 3;
      nwr = 1;
      w = ref_mem[idx];
      for (int k = 0; k < size; k++) w[8 * (off + k) +: 8] = wd[8 * k +: 8];
      ref_mem[idx] = w;
      eword = w;
    end
  endfunction

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input string tag);
    logic ok;
    logic [31:0] er, ew;
    int el, enw, cyc, nwr, idx;
    logic got;
    model(we, f3, a, wd, ok, er, ew, el, enw);
    idx = int'((a / 4) % 64);
    @(negedge clk);
    for (int i = 0; i < 8 && !req_ready; i++) @(negedge clk);
    check({tag, " ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    cyc = 0; nwr = 0; got = 1'b0;
    while (!got && cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid) got = 1'b1;
      else check({tag, " mem_addr"}, mem_addr, {a[31:2], 2'b00});
      if (mem_we) begin
        nwr++;
        check({tag, " mem_din"}, mem_din, ew);
      end
    end
    check({tag, " latency"}, got ? 32'(cyc) : 32'hFFFFFFFF, 32'(el));
    check({tag, " err"}, 32'(rsp_err), 32'(!ok));
    check({tag, " rdata"}, rsp_rdata, er);
    check({tag, " writes"}, 32'(nwr), 32'(enw));
    check({tag, " resp mem_addr"}, mem_addr, 32'd0);
    check({tag, " resp mem_din"}, mem_din, 32'd0);
    check({tag, " memory"}, mem[idx], ref_mem[idx]);
  endtask

  initial begin
    int cnt_wr, pulses, readies;
    logic ok;
    logic [31:0] er, ew;
    int el, enw;

    rst = 1'b1; mem_init = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    repeat (2) @(posedge clk);
    #1;
    check("reset req_ready", 32'(req_ready), 32'd0);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset mem_we", 32'(mem_we), 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset mem_din", mem_din, 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'd0);
    check("reset rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    rst = 1'b0; mem_init = 1'b0;
    #1 check("post-reset ready", 32'(req_ready), 32'd1);

    // loads on the preloaded word 0x8899AABB at 0x10
    do_req(1'b0, 3'b000, 32'h11, 32'h0, "LB 0x11");
    check("LB const", rsp_rdata, 32'hFFFFFFAA);
    do_req(1'b0, 3'b100, 32'h11, 32'h0, "LBU 0x11");
    check("LBU const", rsp_rdata, 32'h000000AA);
    do_req(1'b0, 3'b001, 32'h12, 32'h0, "LH 0x12");
    check("LH const", rsp_rdata, 32'hFFFF8899);
    do_req(1'b0, 3'b101, 32'h12, 32'h0, "LHU 0x12");
    check("LHU const", rsp_rdata, 32'h00008899);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, "LW 0x10");
    check("LW const", rsp_rdata, 32'h8899AABB);

    // stores
    do_req(1'b1, 3'b000, 32'h13, 32'h12345677, "SB 0x13");
    check("SB word", mem[4], 32'h7799AABB);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, "LW after SB");
    check("LW after SB const", rsp_rdata, 32'h7799AABB);
    do_req(1'b1, 3'b001, 32'h12, 32'h0000BEEF, "SH 0x12");
    check("SH word", mem[4], 32'hBEEFAABB);
    do_req(1'b1, 3'b010, 32'h14, 32'hCAFEF00D, "SW 0x14");
    check("SW word", mem[5], 32'hCAFEF00D);

    // rejected requests
    do_req(1'b0, 3'b010, 32'h06, 32'h0, "LW 0x06 misaligned");
    do_req(1'b1, 3'b001, 32'h11, 32'hFFFF, "SH 0x11 misaligned");
    do_req(1'b0, 3'b011, 32'h10, 32'h0, "load f3=011");
    do_req(1'b1, 3'b100, 32'h10, 32'h55, "store f3=100");
    do_req(1'b0, 3'b010, 32'h10, 32'h0, "LW before reset");

    // reset while the SB is in its read phase
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h10; req_wdata = 32'h000000EE;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst mid-RMW mem_we", 32'(mem_we), 32'd0);
    check("rst mid-RMW rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst mid-RMW mem_addr", mem_addr, 32'd0);
    check("rst mid-RMW rsp_rdata", rsp_rdata, 32'd0);
    cnt_wr = 0;
    repeat (2) begin
      @(negedge clk);
      if (mem_we || rsp_valid) cnt_wr++;
    end
    rst = 1'b0;
    #1 check("rst mid-RMW ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    if (mem_we || rsp_valid) cnt_wr++;
    check("rst mid-RMW activity", 32'(cnt_wr), 32'd0);
    check("rst mid-RMW memory", mem[4], ref_mem[4]);

    // req_valid held high: only IDLE cycles accept
    model(1'b0, 3'b010, 32'h10, 32'h0, ok, er, ew, el, enw);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = '0;
    pulses = 0; readies = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (req_ready) readies++;
      if (rsp_valid) begin
        pulses++;
        check("b2b rdata", rsp_rdata, er);
      end
    end
    req_valid = 1'b0;
    check("b2b responses", 32'(pulses), 32'd4);
    check("b2b ready cycles", 32'(readies), 32'd4);

    // random traffic over the first 256 bytes
    for (int n = 0; n < 250; n++) begin
      do_req(1'($urandom), 3'($urandom_range(0, 7)), 32'($urandom_range(0, 255)), $urandom, "random");
    end
    for (int i = 0; i < 64; i++) check("final memory", mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
